// File: rtl/fl_vstream_src.sv
// Dual-stream vector source: fetches x[i] and y[i] alternately from a single-port
// memory with 1-cycle read latency and streams them out on two buffered AXI-style ports.

module fl_vstream_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // A full buffer still accepts a write when a word leaves in the same cycle.
    always_comb begin
        pop      = (count_q != '0) && rd_ready;
        push     = wr_en && ((count_q != CW'(DEPTH)) || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

module fl_vstream_src #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0] base_x,
    input  logic [ADDR_WIDTH-1:0] base_y,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] x_data,
    output logic                  x_valid,
    input  logic                  x_ready,
    output logic                  x_end,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  y_end
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_x_q, base_x_d;
    logic [ADDR_WIDTH-1:0] base_y_q, base_y_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic                  phase_q, phase_d;
    logic                  infl_q, infl_d;
    logic                  infl_y_q, infl_y_d;
    logic                  infl_end_q, infl_end_d;
    logic                  done_q, done_d;

    logic                  x_room, y_room, issue, last_elem;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  x_wr, y_wr;
    logic [DATA_WIDTH:0]   wr_word, x_word, y_word;
    logic [CW-1:0]         x_count, y_count;

    // Room is reserved for the read still in flight so a buffer can never overflow.
    always_comb begin
        x_room    = (x_count + CW'(infl_q && !infl_y_q)) < CW'(FIFO_DEPTH);
        y_room    = (y_count + CW'(infl_q && infl_y_q)) < CW'(FIFO_DEPTH);
        last_elem = (idx_q == len_q - LEN_WIDTH'(1));
        rd_addr   = phase_q ? base_y_q + ADDR_WIDTH'(idx_q)
                            : base_x_q + ADDR_WIDTH'(idx_q);
        issue     = (state_q == RUN) && (phase_q ? y_room : x_room);
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        infl_d     = issue;
        infl_y_d   = phase_q;
        infl_end_d = last_elem;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d  = RUN;
                        len_d    = len;
                        base_x_d = base_x;
                        base_y_d = base_y;
                        idx_d    = '0;
                        phase_d  = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        idx_d   = idx_q + LEN_WIDTH'(1);
                        if (last_elem) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!x_valid && !y_valid && !infl_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            base_x_q   <= '0;
            base_y_q   <= '0;
            idx_q      <= '0;
            phase_q    <= 1'b0;
            infl_q     <= 1'b0;
            infl_y_q   <= 1'b0;
            infl_end_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            infl_q     <= infl_d;
            infl_y_q   <= infl_y_d;
            infl_end_q <= infl_end_d;
            done_q     <= done_d;
        end
    end

    // Returning data goes to whichever stream was targeted by last cycle's read.
    assign x_wr    = infl_q && !infl_y_q;
    assign y_wr    = infl_q && infl_y_q;
    assign wr_word = {infl_end_q, mem_rdata};

    fl_vstream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_x_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (x_wr),
        .wr_data  (wr_word),
        .rd_ready (x_ready),
        .rd_valid (x_valid),
        .rd_data  (x_word),
        .count    (x_count)
    );

    fl_vstream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_y_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (y_wr),
        .wr_data  (wr_word),
        .rd_ready (y_ready),
        .rd_valid (y_valid),
        .rd_data  (y_word),
        .count    (y_count)
    );

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign mem_en   = issue;
    assign mem_addr = (state_q == RUN) ? rd_addr : '0;
    assign x_data   = x_word[DATA_WIDTH-1:0];
    assign x_end    = x_valid && x_word[DATA_WIDTH];
    assign y_data   = y_word[DATA_WIDTH-1:0];
    assign y_end    = y_valid && y_word[DATA_WIDTH];

endmodule

// File: tb/tb_fl_vstream_src.sv
// Directed testbench for fl_vstream_src; the memory returns {seed, address} so every
// delivered word can be predicted from the job's bases and the current seed.

module tb_fl_vstream_src;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len;
    logic [AW-1:0] base_x, base_y;
    logic          busy, done, mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] x_data, y_data;
    logic          x_valid, x_ready, x_end;
    logic          y_valid, y_ready, y_end;

    int            n_cmp;
    int            n_fail;
    logic [15:0]   seed;
    logic [DW:0]   xq[$];
    logic [DW:0]   yq[$];
    logic [AW-1:0] aq[$];
    int            done_cnt;

    fl_vstream_src #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .base_x    (base_x),
        .base_y    (base_y),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_end     (x_end),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .y_end     (y_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory model.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= {seed, mem_addr};
    end

    // Log of everything the DUT hands out, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (x_valid && x_ready) xq.push_back({x_end, x_data});
            if (y_valid && y_ready) yq.push_back({y_end, y_data});
            if (mem_en) aq.push_back(mem_addr);
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_log();
        xq.delete();
        yq.delete();
        aq.delete();
        done_cnt = 0;
    endtask

    task automatic start_job(input logic [LW-1:0] l, input logic [AW-1:0] bx, input logic [AW-1:0] by);
        @(posedge clk); #1;
        start  = 1'b1;
        len    = l;
        base_x = bx;
        base_y = by;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, output int cyc);
        cyc = -1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
        end
        n_cmp++;
        if (cyc < 0) begin
            n_fail++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected a done pulse", max_cycles);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({busy, done, mem_en, x_valid, y_valid, x_end, y_end, mem_addr} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0",
                     {busy, done, mem_en, x_valid, y_valid, x_end, y_end, mem_addr});
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, mem_en, x_valid, y_valid} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %b expected 00000", {busy, done, mem_en, x_valid, y_valid});
        end
    endtask

    task automatic test_basic();
        int            done_cyc;
        logic [AW-1:0] ea;
        logic [DW:0]   ew;
        seed = 16'h1111;
        clear_log();
        start_job(16'd4, 16'h0010, 16'h0020);
        done_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_cmp++;
                if ({mem_en, mem_addr, x_valid} !== {1'b1, 16'h0010, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL first_read: got en=%b addr=%h xv=%b expected en=1 addr=0010 xv=0", mem_en, mem_addr, x_valid);
                end
            end
            if (c == 1) begin
                n_cmp++;
                if ({mem_en, mem_addr, x_valid} !== {1'b1, 16'h0020, 1'b0}) begin
                    n_fail++;
                    $display("[TB] FAIL second_read: got en=%b addr=%h xv=%b expected en=1 addr=0020 xv=0", mem_en, mem_addr, x_valid);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if ({x_valid, x_data} !== {1'b1, 32'h11110010}) begin
                    n_fail++;
                    $display("[TB] FAIL first_x_word: got v=%b d=%h expected v=1 d=11110010", x_valid, x_data);
                end
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL busy_during_job: cycle %0d got %b expected 1", c, busy);
            end
        end
        n_cmp++;
        if (done_cyc != 11 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL done_timing: got cycle %0d busy=%b expected cycle 11 busy=0", done_cyc, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (aq.size() != 8 || xq.size() != 4 || yq.size() != 4 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL basic_counts: got a=%0d x=%0d y=%0d done=%0d expected 8/4/4/1", aq.size(), xq.size(), yq.size(), done_cnt);
        end
        for (int k = 0; k < 8 && k < aq.size(); k++) begin
            ea = (k % 2 == 0) ? AW'(16'h0010 + k / 2) : AW'(16'h0020 + k / 2);
            n_cmp++;
            if (aq[k] !== ea) begin
                n_fail++;
                $display("[TB] FAIL basic_addr[%0d]: got %h expected %h", k, aq[k], ea);
            end
        end
        for (int k = 0; k < 4 && k < xq.size() && k < yq.size(); k++) begin
            ew = {(k == 3), seed, AW'(16'h0010 + k)};
            n_cmp++;
            if (xq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL basic_x[%0d]: got %h expected %h", k, xq[k], ew);
            end
            ew = {(k == 3), seed, AW'(16'h0020 + k)};
            n_cmp++;
            if (yq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL basic_y[%0d]: got %h expected %h", k, yq[k], ew);
            end
        end
    endtask

    task automatic test_zero_len();
        seed = 16'h7777;
        clear_log();
        start_job(16'd0, 16'h0030, 16'h0040);
        @(negedge clk);
        n_cmp++;
        if ({done, busy, mem_en} !== 3'b100) begin
            n_fail++;
            $display("[TB] FAIL zero_len_done: got done=%b busy=%b en=%b expected 1/0/0", done, busy, mem_en);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL zero_len_pulse: got done=%b busy=%b expected 0/0", done, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (aq.size() != 0 || xq.size() != 0 || yq.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL zero_len_counts: got a=%0d x=%0d y=%0d done=%0d expected 0/0/0/1", aq.size(), xq.size(), yq.size(), done_cnt);
        end
    endtask

    task automatic test_y_stall();
        int            cyc;
        logic [AW-1:0] ea;
        logic [DW:0]   ew;
        seed    = 16'h2222;
        y_ready = 1'b0;
        clear_log();
        start_job(16'd8, 16'h0100, 16'h0200);
        for (int s = 0; s < 20; s++) begin
            @(posedge clk); #1;
            if (s >= 4) begin
                n_cmp++;
                if ({y_valid, y_end, y_data} !== {1'b1, 1'b0, 32'h22220200}) begin
                    n_fail++;
                    $display("[TB] FAIL y_hold[%0d]: got v=%b e=%b d=%h expected 1/0/22220200", s, y_valid, y_end, y_data);
                end
            end
        end
        n_cmp++;
        if (mem_en !== 1'b0 || aq.size() != 9 || xq.size() != 5 || yq.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL stall_state: got en=%b a=%0d x=%0d y=%0d expected 0/9/5/0", mem_en, aq.size(), xq.size(), yq.size());
        end
        y_ready = 1'b1;
        wait_done(300, cyc);
        n_cmp++;
        if (aq.size() != 16 || xq.size() != 8 || yq.size() != 8 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL stall_counts: got a=%0d x=%0d y=%0d done=%0d expected 16/8/8/1", aq.size(), xq.size(), yq.size(), done_cnt);
        end
        for (int k = 0; k < 16 && k < aq.size(); k++) begin
            ea = (k % 2 == 0) ? AW'(16'h0100 + k / 2) : AW'(16'h0200 + k / 2);
            n_cmp++;
            if (aq[k] !== ea) begin
                n_fail++;
                $display("[TB] FAIL stall_addr[%0d]: got %h expected %h", k, aq[k], ea);
            end
        end
        for (int k = 0; k < 8 && k < xq.size() && k < yq.size(); k++) begin
            ew = {(k == 7), seed, AW'(16'h0100 + k)};
            n_cmp++;
            if (xq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL stall_x[%0d]: got %h expected %h", k, xq[k], ew);
            end
            ew = {(k == 7), seed, AW'(16'h0200 + k)};
            n_cmp++;
            if (yq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL stall_y[%0d]: got %h expected %h", k, yq[k], ew);
            end
        end
    endtask

    task automatic test_wrap();
        int            cyc;
        logic [AW-1:0] ea;
        logic [DW:0]   ew;
        seed = 16'h3333;
        clear_log();
        start_job(16'd4, 16'hFFFE, 16'h0500);
        wait_done(100, cyc);
        n_cmp++;
        if (aq.size() != 8 || xq.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL wrap_counts: got a=%0d x=%0d expected 8/4", aq.size(), xq.size());
        end
        for (int k = 0; k < 4 && 2 * k < aq.size() && k < xq.size(); k++) begin
            ea = AW'(32'h0000FFFE + k);
            n_cmp++;
            if (aq[2 * k] !== ea) begin
                n_fail++;
                $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", k, aq[2 * k], ea);
            end
            ew = {(k == 3), seed, ea};
            n_cmp++;
            if (xq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL wrap_x[%0d]: got %h expected %h", k, xq[k], ew);
            end
        end
    endtask

    task automatic test_reset_mid();
        int          cyc;
        bit          found;
        logic [DW:0] ew;
        seed  = 16'h4444;
        clear_log();
        start_job(16'd8, 16'h0600, 16'h0700);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 16'h0603) begin
                found = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL reach_elem3: got no read of 0603 expected one");
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mem_en, x_valid, y_valid, x_end, y_end, mem_addr} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midjob_reset: got %h expected 0",
                     {busy, done, mem_en, x_valid, y_valid, x_end, y_end, mem_addr});
        end
        clear_log();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0 || x_valid !== 1'b0 || y_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL aborted_job: got done=%0d busy=%b xv=%b yv=%b expected 0/0/0/0", done_cnt, busy, x_valid, y_valid);
        end
        seed = 16'h5555;
        start_job(16'd2, 16'h0600, 16'h0700);
        wait_done(100, cyc);
        n_cmp++;
        if (aq.size() != 4 || xq.size() != 2 || yq.size() != 2 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL restart_counts: got a=%0d x=%0d y=%0d done=%0d expected 4/2/2/1", aq.size(), xq.size(), yq.size(), done_cnt);
        end
        for (int k = 0; k < 2 && k < xq.size() && k < yq.size(); k++) begin
            ew = {(k == 1), seed, AW'(16'h0600 + k)};
            n_cmp++;
            if (xq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL restart_x[%0d]: got %h expected %h", k, xq[k], ew);
            end
            ew = {(k == 1), seed, AW'(16'h0700 + k)};
            n_cmp++;
            if (yq[k] !== ew) begin
                n_fail++;
                $display("[TB] FAIL restart_y[%0d]: got %h expected %h", k, yq[k], ew);
            end
        end
    endtask

    task automatic test_start_busy();
        int            cyc;
        logic [AW-1:0] ea;
        seed = 16'h6666;
        clear_log();
        start_job(16'd3, 16'h0040, 16'h0050);
        @(posedge clk); #1;
        start  = 1'b1;
        len    = 16'd6;
        base_x = 16'h0080;
        base_y = 16'h0090;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(100, cyc);
        n_cmp++;
        if (aq.size() != 6 || xq.size() != 3 || yq.size() != 3 || done_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL busy_start_counts: got a=%0d x=%0d y=%0d done=%0d expected 6/3/3/1", aq.size(), xq.size(), yq.size(), done_cnt);
        end
        for (int k = 0; k < 6 && k < aq.size(); k++) begin
            ea = (k % 2 == 0) ? AW'(16'h0040 + k / 2) : AW'(16'h0050 + k / 2);
            n_cmp++;
            if (aq[k] !== ea) begin
                n_fail++;
                $display("[TB] FAIL busy_start_addr[%0d]: got %h expected %h", k, aq[k], ea);
            end
        end
        n_cmp++;
        if (xq.size() == 3 && xq[2] !== {1'b1, seed, 16'h0042}) begin
            n_fail++;
            $display("[TB] FAIL busy_start_last_x: got %h expected %h", xq[2], {1'b1, seed, 16'h0042});
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        done_cnt  = 0;
        seed      = 16'h0;
        start     = 1'b0;
        len       = '0;
        base_x    = '0;
        base_y    = '0;
        x_ready   = 1'b1;
        y_ready   = 1'b1;
        mem_rdata = '0;
        test_reset();
        test_basic();
        test_zero_len();
        test_y_stall();
        test_wrap();
        test_reset_mid();
        test_start_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
